// File: rtl/rmgmt_ext_mac_execute_if.sv
// Management-unit <-> extension execute handshake bundle.
// The master drives the issue side (instruction, operands, flush) and the
// slave returns busy plus the one-cycle completion and writeback.
interface rmgmt_ext_mac_execute_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       funct;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [4:0]       rd_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             reg_w;
  logic [4:0]       reg_waddr;
  logic [WIDTH-1:0] reg_wdata;
  logic             exception;
  logic [4:0]       ex_cause;

  modport master (
    output start, funct, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, reg_w, reg_waddr, reg_wdata, exception, ex_cause
  );

  modport slave (
    input  start, funct, rs1_data, rs2_data, rd_in, flush,
    output busy, done, reg_w, reg_waddr, reg_wdata, exception, ex_cause
  );
endinterface

// File: rtl/rmgmt_ext_mac_execute.sv
// RISC-MGMT extension execute stage: iterative shift-add multiply /
// multiply-accumulate with a private accumulator that survives across
// instructions. Responds with a register writeback, completion or exception.
module rmgmt_ext_mac_execute #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic                    CLK,
  input logic                    RST,
  rmgmt_ext_mac_execute_if.slave bus
);

  localparam int unsigned   N        = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [4:0]    CAUSE_ILLEGAL = 5'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    F_MAC     = 2'b00,
    F_MUL     = 2'b01,
    F_CLRACC  = 2'b10,
    F_ILLEGAL = 2'b11
  } funct_t;

  state_t              state_q;
  funct_t              funct_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [WIDTH-1:0]    prod_q;
  logic [WIDTH-1:0]    acc_q;
  logic [CW-1:0]       count_q;

  logic                busy_q;
  logic                done_q;
  logic                reg_w_q;
  logic [4:0]          reg_waddr_q;
  logic [WIDTH-1:0]    reg_wdata_q;
  logic                exception_q;
  logic [4:0]          ex_cause_q;

  logic [BITS_PER_CYCLE-1:0] digit_d;
  logic [WIDTH-1:0]          prod_d;

  // One partial-product step: add multiplicand times the low multiplier digit.
  always_comb begin
    digit_d = mplier_q[BITS_PER_CYCLE-1:0];
    prod_d  = prod_q + (mcand_q * WIDTH'(digit_d));
  end

  // Issue / compute / respond sequencer with registered response outputs.
  // The response is formed on entry to RESP so it is visible in RESP; the
  // accumulator commit happens on leaving RESP so a flush there can cancel it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      funct_q     <= F_MAC;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_w_q     <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      exception_q <= 1'b0;
      ex_cause_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q      <= 1'b0;
          reg_w_q     <= 1'b0;
          exception_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            funct_q     <= funct_t'(bus.funct);
            mcand_q     <= bus.rs1_data;
            mplier_q    <= bus.rs2_data;
            prod_q      <= '0;
            count_q     <= CNT_INIT;
            reg_waddr_q <= bus.rd_in;
            ex_cause_q  <= '0;
            busy_q      <= 1'b1;
            case (funct_t'(bus.funct))
              F_MAC, F_MUL: state_q <= S_COMPUTE;
              F_CLRACC: begin
                state_q     <= S_RESP;
                done_q      <= 1'b1;
                reg_w_q     <= 1'b1;
                reg_wdata_q <= '0;
              end
              F_ILLEGAL: begin
                state_q     <= S_RESP;
                done_q      <= 1'b1;
                exception_q <= 1'b1;
                ex_cause_q  <= CAUSE_ILLEGAL;
              end
            endcase
          end
        end

        S_COMPUTE: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            if (count_q == '0) begin
              state_q     <= S_RESP;
              done_q      <= 1'b1;
              reg_w_q     <= 1'b1;
              reg_wdata_q <= (funct_q == F_MAC) ? (acc_q + prod_d) : prod_d;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end

        S_RESP: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          reg_w_q     <= 1'b0;
          exception_q <= 1'b0;
          if (!bus.flush) begin
            if (funct_q == F_MAC) begin
              acc_q <= reg_wdata_q;
            end else if (funct_q == F_CLRACC) begin
              acc_q <= '0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q & ~bus.flush;
  assign bus.reg_w     = reg_w_q & ~bus.flush;
  assign bus.exception = exception_q & ~bus.flush;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.ex_cause  = ex_cause_q;

endmodule

// File: tb/tb_rmgmt_ext_mac_execute.sv
// Bench for rmgmt_ext_mac_execute: a 1-bit/cycle and a 4-bit/cycle instance,
// randomized operations checked against an arithmetic reference model.
module tb_rmgmt_ext_mac_execute;

  localparam int unsigned W  = 32;
  localparam int unsigned N1 = 32;
  localparam int unsigned N4 = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  rmgmt_ext_mac_execute_if #(.WIDTH(W)) bus ();
  rmgmt_ext_mac_execute_if #(.WIDTH(W)) bus4 ();

  rmgmt_ext_mac_execute #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  rmgmt_ext_mac_execute #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .CLK (clk),
    .RST (rst4),
    .bus (bus4)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] acc_m [2];

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         reg_w;
    logic         exc;
    logic [4:0]   waddr;
    logic [W-1:0] wdata;
    logic [4:0]   cause;
  } outs_t;

  typedef struct packed {
    logic [7:0]   lat;
    logic         reg_w;
    logic [4:0]   waddr;
    logic [W-1:0] wdata;
    logic         exc;
    logic [4:0]   cause;
    logic         busy_ok;
    logic         extra_done;
  } resp_t;

  task automatic set_ops(input bit sel, input logic st, input logic [1:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
    if (!sel) begin
      bus.start = st; bus.funct = f; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    end else begin
      bus4.start = st; bus4.funct = f; bus4.rs1_data = a; bus4.rs2_data = b; bus4.rd_in = rd;
    end
  endtask

  task automatic set_flush(input bit sel, input logic v);
    if (!sel) bus.flush = v;
    else      bus4.flush = v;
  endtask

  function automatic outs_t snap(input bit sel);
    outs_t s;
    if (!sel) s = {bus.busy, bus.done, bus.reg_w, bus.exception,
                   bus.reg_waddr, bus.reg_wdata, bus.ex_cause};
    else      s = {bus4.busy, bus4.done, bus4.reg_w, bus4.exception,
                   bus4.reg_waddr, bus4.reg_wdata, bus4.ex_cause};
    return s;
  endfunction

  function automatic string fmt(input resp_t r);
    return $sformatf("lat=%0d w=%b rd=%0d data=%h exc=%b cause=%0d busy_ok=%b extra_done=%b",
                     r.lat, r.reg_w, r.waddr, r.wdata, r.exc, r.cause, r.busy_ok, r.extra_done);
  endfunction

  // Reference: result from plain wide multiplication, latency from N.
  function automatic resp_t model(input bit sel, input logic [1:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] rd);
    logic [2*W-1:0] full;
    resp_t r;
    int unsigned n;
    n = sel ? N4 : N1;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = '0;
    r.waddr = rd;
    r.busy_ok = 1'b1;
    case (f)
      2'd0: begin
        acc_m[sel] = acc_m[sel] + full[W-1:0];
        r.lat = 8'(n + 1); r.reg_w = 1'b1; r.wdata = acc_m[sel];
      end
      2'd1: begin
        r.lat = 8'(n + 1); r.reg_w = 1'b1; r.wdata = full[W-1:0];
      end
      2'd2: begin
        acc_m[sel] = '0;
        r.lat = 8'd1; r.reg_w = 1'b1; r.wdata = '0;
      end
      default: begin
        r.lat = 8'd1; r.exc = 1'b1; r.cause = 5'd2;
      end
    endcase
    return r;
  endfunction

  // Issue one op at the current negedge and observe its response. With
  // poke set, a junk CLRACC start is driven mid-operation (must be ignored).
  task automatic do_op(input bit sel, input logic [1:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd, input bit poke,
                       output resp_t o);
    outs_t s;
    bit seen;
    o = '0;
    o.lat = 8'hFF;
    o.busy_ok = 1'b1;
    seen = 1'b0;
    set_ops(sel, 1'b1, f, a, b, rd);
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) set_ops(sel, 1'b0, f, a, b, rd);
      if (poke && c == 5) set_ops(sel, 1'b1, 2'b10, ~a, ~b, ~rd);
      if (poke && c == 6) set_ops(sel, 1'b0, f, a, b, rd);
      #1;
      s = snap(sel);
      if (!s.busy) o.busy_ok = 1'b0;
      if (s.done) begin
        seen = 1'b1;
        o.lat = 8'(c);
        o.reg_w = s.reg_w;
        o.waddr = s.waddr;
        o.wdata = s.reg_w ? s.wdata : '0;
        o.exc = s.exc;
        o.cause = s.exc ? s.cause : '0;
      end
    end
    @(negedge clk);
    #1;
    s = snap(sel);
    o.extra_done = s.done;
  endtask

  task automatic test_reset();
    outs_t s;
    for (int i = 0; i < 2; i++) begin
      s = snap(i[0]);
      vectors++;
      if (s !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, s);
      end
    end
  endtask

  task automatic test_mul();
    resp_t o, e;
    do_op(1'b0, 2'd1, 32'd7, 32'd6, 5'd5, 1'b0, o);
    e = model(1'b0, 2'd1, 32'd7, 32'd6, 5'd5);
    vectors++;
    if (o !== e || o.wdata !== 32'd42 || o.lat !== 8'd33) begin
      miscompares++; $display("FAIL mul_7x6: got %s want %s", fmt(o), fmt(e));
    end
    do_op(1'b0, 2'd0, 32'd0, 32'd0, 5'd1, 1'b0, o);
    e = model(1'b0, 2'd0, 32'd0, 32'd0, 5'd1);
    vectors++;
    if (o !== e || o.wdata !== 32'd0) begin
      miscompares++; $display("FAIL acc_after_mul: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_mac();
    resp_t o, e;
    do_op(1'b0, 2'd0, 32'd3, 32'd4, 5'd7, 1'b0, o);
    e = model(1'b0, 2'd0, 32'd3, 32'd4, 5'd7);
    vectors++;
    if (o !== e || o.wdata !== 32'd12) begin
      miscompares++; $display("FAIL mac_3x4: got %s want %s", fmt(o), fmt(e));
    end
    do_op(1'b0, 2'd0, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b0, o);
    e = model(1'b0, 2'd0, 32'hFFFF_FFFF, 32'd2, 5'd8);
    vectors++;
    if (o !== e || o.wdata !== 32'h0000_000A) begin
      miscompares++; $display("FAIL mac_wrap: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_clracc();
    resp_t o, e;
    do_op(1'b0, 2'd2, 32'd0, 32'd0, 5'd9, 1'b0, o);
    e = model(1'b0, 2'd2, 32'd0, 32'd0, 5'd9);
    vectors++;
    if (o !== e || o.lat !== 8'd1) begin
      miscompares++; $display("FAIL clracc: got %s want %s", fmt(o), fmt(e));
    end
    do_op(1'b0, 2'd0, 32'd1, 32'd1, 5'd10, 1'b0, o);
    e = model(1'b0, 2'd0, 32'd1, 32'd1, 5'd10);
    vectors++;
    if (o !== e || o.wdata !== 32'd1) begin
      miscompares++; $display("FAIL mac_after_clr: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_illegal();
    resp_t o, e;
    logic [W-1:0] a, b;
    do_op(1'b0, 2'd3, 32'd5, 32'd5, 5'd17, 1'b0, o);
    e = model(1'b0, 2'd3, 32'd5, 32'd5, 5'd17);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL illegal: got %s want %s", fmt(o), fmt(e));
    end
    a = $urandom; b = $urandom;
    do_op(1'b0, 2'd1, a, b, 5'd18, 1'b0, o);
    e = model(1'b0, 2'd1, a, b, 5'd18);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL mul_after_illegal: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_flush();
    resp_t o, e;
    outs_t s;
    int dn;
    logic [W-1:0] a, b;
    a = $urandom | 32'd1; b = $urandom | 32'd1;
    do_op(1'b0, 2'd0, a, b, 5'd2, 1'b0, o);
    e = model(1'b0, 2'd0, a, b, 5'd2);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL flush_pre_mac: got %s want %s", fmt(o), fmt(e));
    end
    // MAC killed at compute cycle 10: no response, accumulator untouched
    set_ops(1'b0, 1'b1, 2'd0, $urandom, $urandom, 5'd4);
    @(negedge clk);
    set_ops(1'b0, 1'b0, 2'd0, '0, '0, 5'd4);
    for (int c = 2; c <= 10; c++) @(negedge clk);
    set_flush(1'b0, 1'b1);
    @(negedge clk);
    set_flush(1'b0, 1'b0);
    #1;
    s = snap(1'b0);
    vectors++;
    if (s.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy: got %b want 0", s.busy);
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk); #1;
      s = snap(1'b0);
      if (s.done) dn++;
    end
    vectors++;
    if (dn != 0) begin
      miscompares++; $display("FAIL flush_no_done: got %0d done pulses want 0", dn);
    end
    do_op(1'b0, 2'd0, 32'd2, 32'd2, 5'd6, 1'b0, o);
    e = model(1'b0, 2'd0, 32'd2, 32'd2, 5'd6);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL flush_reissue: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_flush_resp();
    resp_t o, e;
    outs_t s;
    int dn;
    // flush during the RESP cycle of a CLRACC: no pulse, acc kept
    set_ops(1'b0, 1'b1, 2'd2, '0, '0, 5'd11);
    @(negedge clk);
    set_ops(1'b0, 1'b0, 2'd2, '0, '0, 5'd11);
    set_flush(1'b0, 1'b1);
    #1;
    s = snap(1'b0);
    vectors++;
    if ({s.done, s.reg_w, s.exc} !== 3'b000) begin
      miscompares++; $display("FAIL flush_resp_pulse: got %b want 000", {s.done, s.reg_w, s.exc});
    end
    @(negedge clk);
    set_flush(1'b0, 1'b0);
    #1;
    s = snap(1'b0);
    vectors++;
    if (s.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_resp_busy: got %b want 0", s.busy);
    end
    do_op(1'b0, 2'd0, 32'd0, 32'd0, 5'd12, 1'b0, o);
    e = model(1'b0, 2'd0, 32'd0, 32'd0, 5'd12);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL flush_resp_acc: got %s want %s", fmt(o), fmt(e));
    end
    // flush with start in IDLE: nothing accepted
    set_ops(1'b0, 1'b1, 2'd1, 32'd3, 32'd3, 5'd13);
    set_flush(1'b0, 1'b1);
    @(negedge clk);
    set_ops(1'b0, 1'b0, 2'd1, '0, '0, 5'd13);
    set_flush(1'b0, 1'b0);
    #1;
    s = snap(1'b0);
    dn = 0;
    vectors++;
    if (s.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_start_busy: got %b want 0", s.busy);
    end
    repeat (40) begin
      @(negedge clk); #1;
      s = snap(1'b0);
      if (s.done) dn++;
    end
    vectors++;
    if (dn != 0) begin
      miscompares++; $display("FAIL flush_start_done: got %0d done pulses want 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    resp_t o, e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      do_op(1'b0, i[0] ? 2'd1 : 2'd0, a, b, 5'(i + 20), 1'b1, o);
      e = model(1'b0, i[0] ? 2'd1 : 2'd0, a, b, 5'(i + 20));
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL back_to_back_%0d: got %s want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_random(input bit sel, input int count);
    resp_t o, e;
    logic [W-1:0] a, b;
    logic [1:0] f;
    logic [4:0] rd;
    int unsigned r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      f = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 4) == 0) a = '1;
      if ($urandom_range(0, 4) == 0) b = '1;
      if ($urandom_range(0, 6) == 0) b = '0;
      rd = 5'($urandom_range(0, 31));
      do_op(sel, f, a, b, rd, 1'b0, o);
      e = model(sel, f, a, b, rd);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_%0d_%0d f=%0d a=%h b=%h: got %s want %s",
                 sel, i, f, a, b, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_bpc4();
    resp_t o, e;
    outs_t s;
    int dn;
    do_op(1'b1, 2'd1, 32'h1234_5678, 32'd9, 5'd3, 1'b0, o);
    e = model(1'b1, 2'd1, 32'h1234_5678, 32'd9, 5'd3);
    vectors++;
    if (o !== e || o.lat !== 8'd9 || o.wdata !== 32'hA3D7_0A38) begin
      miscompares++; $display("FAIL bpc4_mul: got %s want %s", fmt(o), fmt(e));
    end
    test_random(1'b1, 10);
    do_op(1'b1, 2'd0, 32'd5, 32'd7, 5'd14, 1'b0, o);
    e = model(1'b1, 2'd0, 32'd5, 32'd7, 5'd14);
    vectors++;
    if (o !== e) begin
      miscompares++; $display("FAIL bpc4_mac: got %s want %s", fmt(o), fmt(e));
    end
    // reset (together with flush) mid-compute: op dropped, acc cleared
    set_ops(1'b1, 1'b1, 2'd0, 32'd9, 32'd9, 5'd15);
    @(negedge clk);
    set_ops(1'b1, 1'b0, 2'd0, '0, '0, 5'd15);
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    set_flush(1'b1, 1'b1);
    @(negedge clk);
    rst4 = 1'b0;
    set_flush(1'b1, 1'b0);
    #1;
    s = snap(1'b1);
    acc_m[1] = '0;
    vectors++;
    if (s !== '0) begin
      miscompares++; $display("FAIL bpc4_rst_outputs: got %h want 0", s);
    end
    dn = 0;
    repeat (20) begin
      @(negedge clk); #1;
      s = snap(1'b1);
      if (s.done) dn++;
    end
    vectors++;
    if (dn != 0) begin
      miscompares++; $display("FAIL bpc4_rst_done: got %0d done pulses want 0", dn);
    end
    do_op(1'b1, 2'd0, 32'd0, 32'd0, 5'd16, 1'b0, o);
    e = model(1'b1, 2'd0, 32'd0, 32'd0, 5'd16);
    vectors++;
    if (o !== e || o.wdata !== 32'd0) begin
      miscompares++; $display("FAIL bpc4_rst_acc: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    rst4 = 1'b1;
    acc_m[0] = '0;
    acc_m[1] = '0;
    set_ops(1'b0, 1'b0, 2'd0, '0, '0, '0);
    set_ops(1'b1, 1'b0, 2'd0, '0, '0, '0);
    set_flush(1'b0, 1'b0);
    set_flush(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    #1;
    test_reset();
    test_mul();
    test_mac();
    test_clracc();
    test_illegal();
    test_flush();
    test_flush_resp();
    test_back_to_back();
    test_random(1'b0, 30);
    test_bpc4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
